fetch_inflight_ctrl: RTL and testbench

//  Parametrised fetch-stage successor: issues sequential instruction fetches, keeps a FIFO of up to

---
 rtl/fetch_inflight_ctrl_if.sv | 64 ++++++
 rtl/fetch_inflight_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_fetch_inflight_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_inflight_ctrl_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fetch_inflight_ctrl_if
// Bundles every non-clock/reset signal of fetch_inflight_ctrl.
//   master : view taken by fetch_inflight_ctrl (drives fetch requests and
//            decode-side outputs, receives events, responses and stalls)
//   slave  : view taken by the surrounding core / memory / decode
// Signal groups:
//   control events : iRESET_SYNC, iEVENT_*, iREDIRECT_*
//   memory side    : oPREV_FETCH_REQ/ADDR, iPREV_FETCH_LOCK, iPREV_INST_VALID,
//                    iPREV_INST, oPREV_LOCK
//   decode side    : oNEXT_INST_VALID/INST/INST_ADDR/PC, iNEXT_FETCH_STOP,
//                    iNEXT_LOCK
//   status         : oINFLIGHT_COUNT, oDROP_PENDING, oPROTOCOL_ERR
// -----------------------------------------------------------------------------
interface fetch_inflight_ctrl_if #(
    parameter int DEPTH_N = 3
) ();
    logic               iRESET_SYNC;
    logic               iEVENT_HOLD;
    logic               iEVENT_START;
    logic               iEVENT_END;
    logic               iEVENT_SETREG_PCR_SET;
    logic [31:0]        iEVENT_SETREG_PCR;
    logic               iREDIRECT_VALID;
    logic [31:0]        iREDIRECT_ADDR;
    logic               oPREV_FETCH_REQ;
    logic               iPREV_FETCH_LOCK;
    logic [31:0]        oPREV_FETCH_ADDR;
    logic               iPREV_INST_VALID;
    logic [31:0]        iPREV_INST;
    logic               oPREV_LOCK;
    logic               oNEXT_INST_VALID;
    logic [31:0]        oNEXT_INST;
    logic [31:0]        oNEXT_INST_ADDR;
    logic [31:0]        oNEXT_PC;
    logic               iNEXT_FETCH_STOP;
    logic               iNEXT_LOCK;
    logic [DEPTH_N:0]   oINFLIGHT_COUNT;
    logic               oDROP_PENDING;
    logic               oPROTOCOL_ERR;

    modport master (
        input  iRESET_SYNC, iEVENT_HOLD, iEVENT_START, iEVENT_END,
               iEVENT_SETREG_PCR_SET, iEVENT_SETREG_PCR,
               iREDIRECT_VALID, iREDIRECT_ADDR,
               iPREV_FETCH_LOCK, iPREV_INST_VALID, iPREV_INST,
               iNEXT_FETCH_STOP, iNEXT_LOCK,
        output oPREV_FETCH_REQ, oPREV_FETCH_ADDR, oPREV_LOCK,
               oNEXT_INST_VALID, oNEXT_INST, oNEXT_INST_ADDR, oNEXT_PC,
               oINFLIGHT_COUNT, oDROP_PENDING, oPROTOCOL_ERR
    );

    modport slave (
        output iRESET_SYNC, iEVENT_HOLD, iEVENT_START, iEVENT_END,
               iEVENT_SETREG_PCR_SET, iEVENT_SETREG_PCR,
               iREDIRECT_VALID, iREDIRECT_ADDR,
               iPREV_FETCH_LOCK, iPREV_INST_VALID, iPREV_INST,
               iNEXT_FETCH_STOP, iNEXT_LOCK,
        input  oPREV_FETCH_REQ, oPREV_FETCH_ADDR, oPREV_LOCK,
               oNEXT_INST_VALID, oNEXT_INST, oNEXT_INST_ADDR, oNEXT_PC,
               oINFLIGHT_COUNT, oDROP_PENDING, oPROTOCOL_ERR
    );
endinterface

// File: rtl/fetch_inflight_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fetch_inflight_ctrl
// Sequential instruction-fetch issuer. Keeps a FIFO of up to DEPTH in-flight
// fetch addresses, pairs each in-order memory response with its address and
// hands the pair to decode one cycle later. After a flush (redirect, exception
// start, PCR jump) the responses still in flight are discarded by a drop
// counter instead of being waited for.
// Ports:
//   iCLOCK  : clock
//   inRESET : asynchronous reset, active low
//   bus     : fetch_inflight_ctrl_if.master (events, memory side, decode side,
//             status; see the interface file)
// -----------------------------------------------------------------------------
module fetch_inflight_ctrl #(
    parameter int          DEPTH      = 8,
    parameter int          DEPTH_N    = 3,
    parameter logic [31:0] INST_STEP  = 32'h4,
    parameter logic [31:0] RESET_ADDR = 32'h0
) (
    input  logic                  iCLOCK,
    input  logic                  inRESET,
    fetch_inflight_ctrl_if.master bus
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_READ = 1'b1;

    localparam logic [DEPTH_N+1:0] DEPTH_EXT = DEPTH[DEPTH_N+1:0];
    localparam logic [DEPTH_N-1:0] PTR_ONE   = 1;
    localparam logic [DEPTH_N:0]   CNT_ONE   = 1;

    logic [0:0]         state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        fifo_q [DEPTH];
    logic [DEPTH_N-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_N-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_N:0]   live_q, live_d;
    logic [DEPTH_N:0]   drop_q, drop_d;
    logic               valid_q, valid_d;
    logic [31:0]        inst_q, inst_d;
    logic [31:0]        inst_addr_q, inst_addr_d;
    logic [31:0]        pc_q, pc_d;
    logic               err_q, err_d;

    logic               pcr_jump;
    logic               any_event;
    logic               flush;
    logic               issue;
    logic               accept;
    logic               drop_accept;
    logic               live_accept;
    logic               stray_accept;
    logic [DEPTH_N+1:0] outstanding;
    logic [31:0]        head_addr;

    assign pcr_jump  = bus.iEVENT_END & bus.iEVENT_SETREG_PCR_SET;
    assign any_event = bus.iRESET_SYNC | pcr_jump | bus.iEVENT_START
                     | bus.iEVENT_HOLD | bus.iREDIRECT_VALID;
    // A redirect masked by HOLD is ignored entirely, so it does not flush.
    assign flush     = !bus.iRESET_SYNC
                     & (pcr_jump | bus.iEVENT_START
                        | (!bus.iEVENT_HOLD & bus.iREDIRECT_VALID));

    // Live and to-be-dropped fetches share the DEPTH budget.
    assign outstanding = {1'b0, live_q} + {1'b0, drop_q};
    assign issue = (state_q == ST_READ) && !any_event && !bus.iPREV_FETCH_LOCK
                && !bus.iNEXT_FETCH_STOP && (outstanding < DEPTH_EXT);

    assign accept       = bus.iPREV_INST_VALID && !bus.iNEXT_LOCK;
    assign drop_accept  = accept && (drop_q != '0);
    assign live_accept  = accept && (drop_q == '0) && (live_q != '0);
    assign stray_accept = accept && (drop_q == '0) && (live_q == '0);
    assign head_addr    = fifo_q[rd_ptr_q];

    always_comb begin
        // NOTE: every signal gets a default here so no path through the
        // branches below can leave one unassigned and infer a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        live_d      = live_q;
        drop_d      = drop_q;
        valid_d     = valid_q;
        inst_d      = inst_q;
        inst_addr_d = inst_addr_q;
        pc_d        = pc_q;
        err_d       = err_q | stray_accept;

        if (bus.iRESET_SYNC) begin
            state_d     = ST_IDLE;
            addr_d      = RESET_ADDR;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            live_d      = '0;
            drop_d      = '0;
            valid_d     = 1'b0;
            inst_d      = '0;
            inst_addr_d = '0;
            pc_d        = '0;
            err_d       = 1'b0;
        end else begin
            // Fetch address and state, by event priority.
            if (pcr_jump) begin
                addr_d  = bus.iEVENT_SETREG_PCR & ~32'h1;
                state_d = ST_READ;
            end else if (bus.iEVENT_START) begin
                addr_d  = RESET_ADDR;
                state_d = ST_IDLE;
            end else if (bus.iEVENT_HOLD) begin
                state_d = ST_IDLE;
            end else if (bus.iREDIRECT_VALID) begin
                addr_d  = bus.iREDIRECT_ADDR;
                state_d = ST_IDLE;
            end else begin
                state_d = ST_READ;
                if (issue) addr_d = addr_q + INST_STEP;
            end

            if (flush) begin
                // Every live entry becomes a response to throw away; a
                // response accepted this very cycle already consumed one.
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                live_d   = '0;
                drop_d   = drop_q + live_q
                         - {{DEPTH_N{1'b0}}, accept && (outstanding != '0)};
                valid_d  = 1'b0;
            end else begin
                if (issue)       wr_ptr_d = wr_ptr_q + PTR_ONE;
                if (live_accept) rd_ptr_d = rd_ptr_q + PTR_ONE;
                live_d = live_q + {{DEPTH_N{1'b0}}, issue}
                                - {{DEPTH_N{1'b0}}, live_accept};
                if (drop_accept) drop_d = drop_q - CNT_ONE;
                if (!bus.iNEXT_LOCK) begin
                    valid_d = live_accept;
                    if (live_accept) begin
                        inst_d      = bus.iPREV_INST;
                        inst_addr_d = head_addr;
                        pc_d        = head_addr + INST_STEP;
                    end
                end
            end
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q     <= ST_IDLE;
            addr_q      <= RESET_ADDR;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            live_q      <= '0;
            drop_q      <= '0;
            valid_q     <= 1'b0;
            inst_q      <= '0;
            inst_addr_q <= '0;
            pc_q        <= '0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state_q     <= state_d;
            addr_q      <= addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            live_q      <= live_d;
            drop_q      <= drop_d;
            valid_q     <= valid_d;
            inst_q      <= inst_d;
            inst_addr_q <= inst_addr_d;
            pc_q        <= pc_d;
            err_q       <= err_d;
        end
    end

    // NOTE: the address FIFO storage is deliberately not reset; an entry is
    // only ever read after it was written, as tracked by live_q and the
    // pointers, which are reset.
    always_ff @(posedge iCLOCK) begin
        if (issue) fifo_q[wr_ptr_q] <= addr_q;
    end

    assign bus.oPREV_FETCH_REQ  = issue;
    assign bus.oPREV_FETCH_ADDR = addr_q;
    assign bus.oPREV_LOCK       = bus.iNEXT_LOCK;
    assign bus.oNEXT_INST_VALID = valid_q;
    assign bus.oNEXT_INST       = inst_q;
    assign bus.oNEXT_INST_ADDR  = inst_addr_q;
    assign bus.oNEXT_PC         = pc_q;
    assign bus.oINFLIGHT_COUNT  = outstanding[DEPTH_N:0];
    assign bus.oDROP_PENDING    = (drop_q != '0);
    assign bus.oPROTOCOL_ERR    = err_q;
endmodule

// File: tb/tb_fetch_inflight_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for fetch_inflight_ctrl: a directed vector table,
// hand-written corner sequences and randomized traffic against a queue-based
// reference model.
module tb_fetch_inflight_ctrl;
    localparam int          DEPTH   = 8;
    localparam int          DEPTH_N = 3;
    localparam logic [31:0] STEP    = 32'h4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_inflight_ctrl_if #(.DEPTH_N(DEPTH_N)) bus ();

    fetch_inflight_ctrl #(
        .DEPTH(DEPTH), .DEPTH_N(DEPTH_N), .INST_STEP(STEP), .RESET_ADDR(32'h0)
    ) dut (
        .iCLOCK (clk),
        .inRESET(rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] live[$];
    int          m_drop;
    logic [31:0] m_addr;
    bit          m_ready;
    bit          m_valid;
    logic [31:0] m_inst, m_iaddr, m_pc;
    bit          m_err;
    bit          use_model = 1'b0;

    function automatic void model_reset();
        live.delete();
        m_drop = 0; m_addr = 32'h0; m_ready = 1'b0; m_valid = 1'b0;
        m_inst = 32'h0; m_iaddr = 32'h0; m_pc = 32'h0; m_err = 1'b0;
    endfunction

    function automatic bit model_req();
        bit ev;
        ev = bus.iRESET_SYNC || (bus.iEVENT_END && bus.iEVENT_SETREG_PCR_SET)
          || bus.iEVENT_START || bus.iEVENT_HOLD || bus.iREDIRECT_VALID;
        return m_ready && !ev && !bus.iPREV_FETCH_LOCK && !bus.iNEXT_FETCH_STOP
            && (live.size() + m_drop < DEPTH);
    endfunction

    task automatic model_update();
        bit req, pj, flush, acc, popped;
        logic [31:0] a;
        req = model_req();
        if (bus.iRESET_SYNC) begin
            model_reset();
            return;
        end
        pj     = bus.iEVENT_END && bus.iEVENT_SETREG_PCR_SET;
        flush  = pj || bus.iEVENT_START || (!bus.iEVENT_HOLD && bus.iREDIRECT_VALID);
        acc    = bus.iPREV_INST_VALID && !bus.iNEXT_LOCK;
        popped = 1'b0;
        a      = 32'h0;
        if (acc) begin
            if (m_drop > 0) m_drop--;
            else if (live.size() > 0) begin a = live.pop_front(); popped = 1'b1; end
            else m_err = 1'b1;
        end
        if (flush) begin
            m_drop += live.size();
            live.delete();
            m_valid = 1'b0;
        end else if (!bus.iNEXT_LOCK) begin
            m_valid = popped;
            if (popped) begin m_inst = bus.iPREV_INST; m_iaddr = a; m_pc = a + STEP; end
        end
        if (req) begin live.push_back(m_addr); m_addr = m_addr + STEP; end
        if (pj) begin m_addr = bus.iEVENT_SETREG_PCR & 32'hFFFF_FFFE; m_ready = 1'b1; end
        else if (bus.iEVENT_START) begin m_addr = 32'h0; m_ready = 1'b0; end
        else if (bus.iEVENT_HOLD) m_ready = 1'b0;
        else if (bus.iREDIRECT_VALID) begin m_addr = bus.iREDIRECT_ADDR; m_ready = 1'b0; end
        else m_ready = 1'b1;
    endtask

    task automatic compare_model();
        check("req", 32'(bus.oPREV_FETCH_REQ), 32'(model_req()));
        check("fetch_addr", bus.oPREV_FETCH_ADDR, m_addr);
        check("inflight", 32'(bus.oINFLIGHT_COUNT), 32'(live.size() + m_drop));
        check("drop_pending", 32'(bus.oDROP_PENDING), 32'(m_drop != 0));
        check("valid", 32'(bus.oNEXT_INST_VALID), 32'(m_valid));
        if (m_valid) begin
            check("inst", bus.oNEXT_INST, m_inst);
            check("inst_addr", bus.oNEXT_INST_ADDR, m_iaddr);
            check("next_pc", bus.oNEXT_PC, m_pc);
        end
        check("proto_err", 32'(bus.oPROTOCOL_ERR), 32'(m_err));
        check("prev_lock", 32'(bus.oPREV_LOCK), 32'(bus.iNEXT_LOCK));
    endtask

    // ---------------- cycle helpers ----------------
    logic        s_req, s_valid, s_drop, s_err;
    logic [31:0] s_addr, s_iaddr, s_inst, s_pc;
    logic [3:0]  s_cnt;

    task automatic idle_inputs();
        bus.iRESET_SYNC = 1'b0; bus.iEVENT_HOLD = 1'b0; bus.iEVENT_START = 1'b0;
        bus.iEVENT_END = 1'b0; bus.iEVENT_SETREG_PCR_SET = 1'b0; bus.iEVENT_SETREG_PCR = 32'h0;
        bus.iREDIRECT_VALID = 1'b0; bus.iREDIRECT_ADDR = 32'h0;
        bus.iPREV_FETCH_LOCK = 1'b0; bus.iPREV_INST_VALID = 1'b0; bus.iPREV_INST = 32'h0;
        bus.iNEXT_FETCH_STOP = 1'b0; bus.iNEXT_LOCK = 1'b0;
    endtask

    // Inputs are set at the falling edge; outputs are sampled 1 ns later.
    task automatic cycle();
        #1;
        s_req = bus.oPREV_FETCH_REQ; s_addr = bus.oPREV_FETCH_ADDR;
        s_cnt = bus.oINFLIGHT_COUNT; s_drop = bus.oDROP_PENDING;
        s_valid = bus.oNEXT_INST_VALID; s_iaddr = bus.oNEXT_INST_ADDR;
        s_inst = bus.oNEXT_INST; s_pc = bus.oNEXT_PC; s_err = bus.oPROTOCOL_ERR;
        if (use_model) compare_model();
        @(posedge clk);
        if (use_model) model_update();
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          fl, st, nl, rv;
        logic [31:0] rd;
        bit          ereq;
        logic [31:0] eaddr;
        logic [3:0]  ecnt;
        bit          eval;
        logic [31:0] eiaddr, einst;
        bit          eerr;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input bit fl, st, nl, rv, input logic [31:0] rd,
                                input bit ereq, input logic [31:0] eaddr, input logic [3:0] ecnt,
                                input bit eval, input logic [31:0] eiaddr, einst, input bit eerr);
        vec_t v;
        v.fl = fl; v.st = st; v.nl = nl; v.rv = rv; v.rd = rd;
        v.ereq = ereq; v.eaddr = eaddr; v.ecnt = ecnt; v.eval = eval;
        v.eiaddr = eiaddr; v.einst = einst; v.eerr = eerr;
        return v;
    endfunction

    // scratch for sequences
    logic [31:0] reqs[$];
    logic [1:0]  hist;
    logic [31:0] exp_ia, first_iaddr, first_raddr;
    int          n_valid, max_cnt, n_req, first_valid_idx, first_req_idx;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        //          fl    st    nl    rv    rdata         req   addr   cnt  val   iaddr  inst          err
        vecs[0]  = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,4'd0,1'b0,32'h0,32'h0,        1'b0);
        vecs[1]  = mk(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0,4'd0,1'b0,32'h0,32'h0,        1'b0);
        vecs[2]  = mk(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h4,4'd1,1'b0,32'h0,32'h0,        1'b0);
        vecs[3]  = mk(1'b0,1'b0,1'b0,1'b1,32'hAAAA0001, 1'b1,32'h4,4'd1,1'b0,32'h0,32'h0,        1'b0);
        vecs[4]  = mk(1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,32'h8,4'd1,1'b1,32'h0,32'hAAAA0001, 1'b0);
        vecs[5]  = mk(1'b0,1'b0,1'b0,1'b1,32'hBBBB0002, 1'b1,32'h8,4'd1,1'b0,32'h0,32'h0,        1'b0);
        vecs[6]  = mk(1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,32'hC,4'd1,1'b1,32'h4,32'hBBBB0002, 1'b0);
        vecs[7]  = mk(1'b0,1'b1,1'b1,1'b1,32'hCCCC0003, 1'b0,32'hC,4'd1,1'b0,32'h0,32'h0,        1'b0);
        vecs[8]  = mk(1'b0,1'b1,1'b0,1'b1,32'hCCCC0003, 1'b0,32'hC,4'd1,1'b0,32'h0,32'h0,        1'b0);
        vecs[9]  = mk(1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,32'hC,4'd0,1'b1,32'h8,32'hCCCC0003, 1'b0);
        vecs[10] = mk(1'b0,1'b1,1'b0,1'b1,32'hDEAD0000, 1'b0,32'hC,4'd0,1'b0,32'h0,32'h0,        1'b0);
        vecs[11] = mk(1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,32'hC,4'd0,1'b0,32'h0,32'h0,        1'b1);

        do_reset();
        use_model = 1'b0;
        foreach (vecs[i]) begin
            bus.iPREV_FETCH_LOCK = vecs[i].fl; bus.iNEXT_FETCH_STOP = vecs[i].st;
            bus.iNEXT_LOCK = vecs[i].nl; bus.iPREV_INST_VALID = vecs[i].rv;
            bus.iPREV_INST = vecs[i].rd;
            cycle();
            check($sformatf("vec%0d_req", i), 32'(s_req), 32'(vecs[i].ereq));
            check($sformatf("vec%0d_addr", i), s_addr, vecs[i].eaddr);
            check($sformatf("vec%0d_cnt", i), 32'(s_cnt), 32'(vecs[i].ecnt));
            check($sformatf("vec%0d_valid", i), 32'(s_valid), 32'(vecs[i].eval));
            if (vecs[i].eval) begin
                check($sformatf("vec%0d_iaddr", i), s_iaddr, vecs[i].eiaddr);
                check($sformatf("vec%0d_inst", i), s_inst, vecs[i].einst);
                check($sformatf("vec%0d_pc", i), s_pc, vecs[i].eiaddr + STEP);
            end
            check($sformatf("vec%0d_err", i), 32'(s_err), 32'(vecs[i].eerr));
        end

        use_model = 1'b1;

        // Sequential: memory answers each request two cycles later.
        do_reset();
        reqs.delete(); hist = 2'b00; exp_ia = 32'h0; n_valid = 0; max_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            bus.iPREV_INST_VALID = hist[1];
            if (hist[1]) bus.iPREV_INST = reqs.pop_front() ^ 32'hA5A5_0000;
            cycle();
            if (s_valid) begin
                check("seq_iaddr", s_iaddr, exp_ia);
                check("seq_inst", s_inst, exp_ia ^ 32'hA5A5_0000);
                exp_ia = exp_ia + STEP;
                n_valid++;
            end
            if (s_req) reqs.push_back(s_addr);
            if (int'(s_cnt) > max_cnt) max_cnt = int'(s_cnt);
            hist = {hist[0], s_req};
        end
        check("seq_max_inflight_le3", 32'(max_cnt <= 3), 32'h1);
        check("seq_valid_count", 32'(n_valid), 32'd16);

        // Full: no responses, exactly DEPTH requests.
        do_reset();
        n_req = 0; first_raddr = 32'h0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (s_req) begin n_req++; first_raddr = s_addr; end
        end
        check("full_nreq", 32'(n_req), 32'd8);
        check("full_last_addr", first_raddr, 32'h1C);
        check("full_req_off", 32'(s_req), 32'h0);
        check("full_count", 32'(s_cnt), 32'd8);

        // Redirect with 5 in flight.
        do_reset();
        repeat (6) cycle();
        bus.iREDIRECT_VALID = 1'b1; bus.iREDIRECT_ADDR = 32'h100;
        cycle();
        check("redir_cnt_before", 32'(s_cnt), 32'd5);
        first_valid_idx = -1; first_req_idx = -1; first_iaddr = 32'h0; first_raddr = 32'h0;
        for (int i = 0; i < 10; i++) begin
            bus.iPREV_INST_VALID = 1'b1; bus.iPREV_INST = 32'h1000 + 32'(i);
            cycle();
            if (i == 0) begin
                check("redir_drop_pending", 32'(s_drop), 32'h1);
                check("redir_cnt_after", 32'(s_cnt), 32'd5);
            end
            if (s_valid && first_valid_idx < 0) begin first_valid_idx = i; first_iaddr = s_iaddr; end
            if (s_req && first_req_idx < 0) begin first_req_idx = i; first_raddr = s_addr; end
        end
        check("redir_first_req_idx", 32'(first_req_idx), 32'd1);
        check("redir_first_req_addr", first_raddr, 32'h100);
        check("redir_first_valid_idx", 32'(first_valid_idx), 32'd6);
        check("redir_first_valid_addr", first_iaddr, 32'h100);

        // Redirect together with a live response, 3 in flight.
        do_reset();
        repeat (4) cycle();
        bus.iREDIRECT_VALID = 1'b1; bus.iREDIRECT_ADDR = 32'h200;
        bus.iPREV_INST_VALID = 1'b1; bus.iPREV_INST = 32'h77;
        cycle();
        check("redir_live_cnt_before", 32'(s_cnt), 32'd3);
        cycle();
        check("redir_live_cnt_after", 32'(s_cnt), 32'd2);
        check("redir_live_drop", 32'(s_drop), 32'h1);
        check("redir_live_valid", 32'(s_valid), 32'h0);

        // PCR jump (odd target) then wrap-around.
        do_reset();
        repeat (3) cycle();
        bus.iEVENT_END = 1'b1; bus.iEVENT_SETREG_PCR_SET = 1'b1; bus.iEVENT_SETREG_PCR = 32'h2003;
        cycle();
        check("pcr_req_during_event", 32'(s_req), 32'h0);
        cycle();
        check("pcr_req_next", 32'(s_req), 32'h1);
        check("pcr_addr_next", s_addr, 32'h2002);
        bus.iEVENT_END = 1'b1; bus.iEVENT_SETREG_PCR_SET = 1'b1; bus.iEVENT_SETREG_PCR = 32'hFFFF_FFFC;
        cycle();
        cycle();
        check("wrap_req0", 32'(s_req), 32'h1);
        check("wrap_addr0", s_addr, 32'hFFFF_FFFC);
        cycle();
        check("wrap_req1", 32'(s_req), 32'h1);
        check("wrap_addr1", s_addr, 32'h0);

        // Unsolicited response: sticky error until synchronous reset.
        do_reset();
        bus.iPREV_INST_VALID = 1'b1;
        cycle();
        repeat (3) begin
            bus.iNEXT_FETCH_STOP = 1'b1;
            cycle();
            check("proto_err_sticky", 32'(s_err), 32'h1);
        end
        bus.iRESET_SYNC = 1'b1;
        cycle();
        cycle();
        check("proto_err_cleared", 32'(s_err), 32'h0);
        check("sync_reset_cnt", 32'(s_cnt), 32'h0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (live.size() + m_drop > 0) bus.iPREV_INST_VALID = ($urandom_range(2) != 0);
            else bus.iPREV_INST_VALID = ($urandom_range(60) == 0);
            bus.iPREV_INST        = $urandom;
            bus.iPREV_FETCH_LOCK  = ($urandom_range(4) == 0);
            bus.iNEXT_FETCH_STOP  = ($urandom_range(7) == 0);
            bus.iNEXT_LOCK        = ($urandom_range(5) == 0);
            bus.iREDIRECT_VALID   = ($urandom_range(19) == 0);
            bus.iREDIRECT_ADDR    = $urandom & 32'hFFFF_FFFC;
            bus.iEVENT_HOLD       = ($urandom_range(24) == 0);
            bus.iEVENT_START      = ($urandom_range(39) == 0);
            bus.iEVENT_END        = ($urandom_range(29) == 0);
            bus.iEVENT_SETREG_PCR_SET = ($urandom_range(1) == 0);
            bus.iEVENT_SETREG_PCR = $urandom;
            bus.iRESET_SYNC       = ($urandom_range(199) == 0);
            cycle();
            check("rand_inflight_le_depth", 32'(int'(s_cnt) <= DEPTH), 32'h1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
